regfile_scrub: RTL and testbench

//   Parametrised general-purpose register file for the multicycle MIPS datapath.

---
 rtl/regfile_scrub_if.sv | 31 +++
 rtl/regfile_scrub.sv | 97 +++++++++
 tb/tb_regfile_scrub.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scrub_if.sv
// Register-file access bundle: read ports, write port, debug slice and scrub status.
// The control side uses the master modport; the register file uses slave.
interface regfile_scrub_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int DBG_W  = 16
);
  localparam int NSLICE = DATA_W / DBG_W;
  localparam int SEL_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     reg_we;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [SEL_W-1:0]         dbg_sel;
  logic [DBG_W-1:0]         dbg_data;
  logic                     busy;

  modport master (
    output rd_addr, wr_addr, wr_data, reg_we, dbg_addr, dbg_sel,
    input  rd_data, dbg_data, busy
  );

  modport slave (
    input  rd_addr, wr_addr, wr_data, reg_we, dbg_addr, dbg_sel,
    output rd_data, dbg_data, busy
  );
endinterface

// File: rtl/regfile_scrub.sv
// Multi-port register file with optional write-through bypass, a debug slice port
// and a reset-triggered scrub that zeroes one register per cycle while busy is high.
module regfile_scrub #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int DBG_W    = 16,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_scrub_if.slave  rf
);
  localparam int NSLICE = DATA_W / DBG_W;
  localparam int SEL_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int PW     = ADDR_W + 1;
  localparam logic [PW-1:0] NUM_REGS_C = PW'(NUM_REGS);
  localparam logic [PW-1:0] LAST_C     = PW'(NUM_REGS - 1);

  logic [DATA_W-1:0]        regs_r [NUM_REGS];
  logic [PW-1:0]            clr_ptr_r;
  logic                     busy_r;
  logic                     wr_ok_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0]        dbg_word_s;
  logic [DBG_W-1:0]         dbg_data_s;

  // Register 0 and out-of-range addresses never match, so they read as zero.
  function automatic logic [DATA_W-1:0] stored_word(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] word;
    word = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      word = (addr == ADDR_W'(r)) ? regs_r[r] : word;
    end
    return word;
  endfunction

  assign wr_ok_s = rf.reg_we && !busy_r && !rst && (rf.wr_addr != '0) &&
                   ({1'b0, rf.wr_addr} < NUM_REGS_C);

  // Scrub control and register array update.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 1'b1;
      clr_ptr_r <= '0;
    end else if (busy_r) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (clr_ptr_r == PW'(i)) begin
          regs_r[i] <= '0;
        end
      end
      clr_ptr_r <= clr_ptr_r + PW'(1);
      if (clr_ptr_r == LAST_C) begin
        busy_r <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok_s && ({1'b0, rf.wr_addr} == PW'(i))) begin
          regs_r[i] <= rf.wr_data;
        end
      end
    end
  end

  // Read ports; wr_ok_s already excludes register 0 and out-of-range targets.
  always_comb begin
    rd_data_s = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (busy_r) begin
        rd_data_s[p*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && wr_ok_s && (rf.rd_addr[p*ADDR_W +: ADDR_W] == rf.wr_addr)) begin
        rd_data_s[p*DATA_W +: DATA_W] = rf.wr_data;
      end else begin
        rd_data_s[p*DATA_W +: DATA_W] = stored_word(rf.rd_addr[p*ADDR_W +: ADDR_W]);
      end
    end
  end

  // Debug slice; selects beyond the last slice fall through to zero.
  always_comb begin
    dbg_word_s = '0;
    dbg_data_s = '0;
    if (busy_r) begin
      dbg_word_s = '0;
    end else begin
      dbg_word_s = stored_word(rf.dbg_addr);
    end
    for (int s = 0; s < NSLICE; s++) begin
      dbg_data_s = (rf.dbg_sel == SEL_W'(s)) ? dbg_word_s[s*DBG_W +: DBG_W] : dbg_data_s;
    end
  end

  assign rf.rd_data  = rd_data_s;
  assign rf.dbg_data = dbg_data_s;
  assign rf.busy     = busy_r;
endmodule

// File: tb/tb_regfile_scrub.sv
// Scoreboard bench: two register files (16 regs with bypass, 12 regs without) share stimulus
// and are checked every cycle against an array-based reference model.
module tb_regfile_scrub;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int GW = 16;

  typedef struct {
    logic [31:0] val [8];
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_scrub_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .DBG_W(GW)) bus_a ();
  regfile_scrub_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .DBG_W(GW)) bus_b ();

  regfile_scrub #(.DATA_W(DW), .NUM_REGS(16), .ADDR_W(AW), .NUM_RD(NR), .DBG_W(GW), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .rf(bus_a));
  regfile_scrub #(.DATA_W(DW), .NUM_REGS(12), .ADDR_W(AW), .NUM_RD(NR), .DBG_W(GW), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .rf(bus_b));

  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b
  logic [31:0] mem [2][16];
  bit          busy_m [2];
  int          left_m [2];
  bit          known = 1'b0;
  bit          cur_rst, cur_we;
  int          cur_wa;
  logic [31:0] cur_wd;

  function automatic int nregs(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic bit wr_qual(input int d);
    return cur_we && !cur_rst && !busy_m[d] && cur_wa != 0 && cur_wa < nregs(d);
  endfunction

  function automatic logic [31:0] model_read(input int d, input int a);
    if (busy_m[d] || a == 0 || a >= nregs(d)) return 32'h0;
    if (d == 0 && wr_qual(d) && a == cur_wa) return cur_wd;
    return mem[d][a];
  endfunction

  function automatic logic [31:0] model_dbg(input int d, input int a, input int sel);
    logic [31:0] w;
    if (busy_m[d] || a == 0 || a >= nregs(d) || sel > 1) return 32'h0;
    w = mem[d][a];
    return (w >> (sel * 16)) & 32'h0000_FFFF;
  endfunction

  function automatic string name_of(input int k);
    case (k)
      0: return "a_busy";
      1: return "a_rd0";
      2: return "a_rd1";
      3: return "a_dbg";
      4: return "b_busy";
      5: return "b_rd0";
      6: return "b_rd1";
      7: return "b_dbg";
      default: return "unknown";
    endcase
  endfunction

  task automatic cyc(input bit r, input bit we, input int wa, input logic [31:0] wd,
                     input int a0, input int a1, input int da, input int ds);
    exp_t e;
    logic [4:0] a0v, a1v, wav, dav;
    a0v = AW'(a0); a1v = AW'(a1); wav = AW'(wa); dav = AW'(da);
    rst = r;
    bus_a.rd_addr = {a1v, a0v};   bus_b.rd_addr = {a1v, a0v};
    bus_a.wr_addr = wav;          bus_b.wr_addr = wav;
    bus_a.wr_data = wd;           bus_b.wr_data = wd;
    bus_a.reg_we = we;            bus_b.reg_we = we;
    bus_a.dbg_addr = dav;         bus_b.dbg_addr = dav;
    bus_a.dbg_sel = 1'(ds);       bus_b.dbg_sel = 1'(ds);
    cur_rst = r; cur_we = we; cur_wa = wa; cur_wd = wd;
    if (known) begin
      for (int d = 0; d < 2; d++) begin
        e.val[d*4+0] = {31'h0, busy_m[d]};
        e.val[d*4+1] = model_read(d, a0);
        e.val[d*4+2] = model_read(d, a1);
        e.val[d*4+3] = model_dbg(d, da, ds);
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        busy_m[d] = 1'b1;
        left_m[d] = nregs(d);
      end else if (busy_m[d]) begin
        left_m[d] = left_m[d] - 1;
        if (left_m[d] == 0) begin
          busy_m[d] = 1'b0;
          for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
        end
      end else if (wr_qual(d)) begin
        mem[d][wa] = wd;
      end
    end
    if (r) known = 1'b1;
  endtask

  task automatic idle(input int a0, input int a1);
    cyc(1'b0, 1'b0, 0, 32'h0, a0, a1, a0, 0);
  endtask

  // Monitor: compares every presented output set against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act [8];
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act[0] = {31'h0, bus_a.busy};
      act[1] = bus_a.rd_data[31:0];
      act[2] = bus_a.rd_data[63:32];
      act[3] = {16'h0, bus_a.dbg_data};
      act[4] = {31'h0, bus_b.busy};
      act[5] = bus_b.rd_data[31:0];
      act[6] = bus_b.rd_data[63:32];
      act[7] = {16'h0, bus_b.dbg_data};
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (act[k] !== e.val[k]) begin
          errors++;
          $display("FAIL %s at %0t: got %h expected %h", name_of(k), $time, act[k], e.val[k]);
        end
      end
    end
  end

  initial begin
    // Scrub after a two-cycle reset, then sweep every address
    cyc(1'b1, 1'b0, 0, 32'h0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 32'h0, 1, 2, 1, 0);
    for (int i = 0; i < 18; i++) idle(i % 16, 15 - (i % 16));
    for (int i = 0; i < 16; i++) idle(i, 15 - i);

    // Write/read, register 0 protection
    cyc(1'b0, 1'b1, 5, 32'hDEAD_BEEF, 5, 0, 5, 0);
    idle(5, 0);
    cyc(1'b0, 1'b1, 0, 32'h0000_1234, 0, 5, 0, 0);
    idle(0, 5);

    // Same-cycle write/read: bypass on dut_a, old value on dut_b
    cyc(1'b0, 1'b1, 7, 32'hA5A5_A5A5, 7, 5, 7, 1);
    idle(7, 7);

    // Mid-scrub reset with a write attempted while busy
    cyc(1'b0, 1'b1, 3, 32'h3333_3333, 3, 7, 3, 0);
    cyc(1'b1, 1'b0, 0, 32'h0, 3, 7, 3, 0);
    for (int i = 0; i < 5; i++) idle(3, 7);
    cyc(1'b1, 1'b0, 0, 32'h0, 3, 7, 3, 0);
    for (int i = 0; i < 18; i++) begin
      if (i == 4) cyc(1'b0, 1'b1, 3, 32'h0BAD_0003, 3, 7, 3, 0);
      else idle(3, 7);
    end
    idle(3, 7);

    // Debug slices and range boundaries (13 valid only in dut_a, 11 last valid in dut_b)
    cyc(1'b0, 1'b1, 9, 32'h8765_4321, 9, 9, 9, 1);
    cyc(1'b0, 1'b0, 0, 32'h0, 9, 0, 9, 1);
    cyc(1'b0, 1'b0, 0, 32'h0, 9, 0, 9, 0);
    cyc(1'b0, 1'b1, 13, 32'h1313_1313, 13, 9, 13, 0);
    cyc(1'b0, 1'b1, 11, 32'h1111_1111, 13, 11, 13, 1);
    cyc(1'b0, 1'b1, 12, 32'h1212_1212, 11, 12, 11, 1);
    cyc(1'b0, 1'b1, 31, 32'h3131_3131, 12, 31, 12, 0);
    idle(31, 11);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 500; n++) begin
      bit r;
      int wa;
      r  = ($urandom_range(0, 63) == 0);
      wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 17));
      cyc(r, 1'($urandom_range(0, 1)), wa, $urandom,
          ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 17)),
          int'($urandom_range(0, 17)), int'($urandom_range(0, 17)), int'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
